uart_rx: RTL and testbench

Standalone UART receiver that deserializes an asynchronous 8-bit serial stream on `rxd` into parallel bytes. It is the receive counterpart to the team's `uart` transmitter. It presents each byte on a `rx_rdy`/`rx_ack` handshake, matching the handshake the `uart` top uses. It sits between the pad and the consumer logic and flags parity, framing and overrun errors per byte.

---
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_rx.sv | 177 +++++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx and its consumer.
// rx_data and the error flags are valid while rx_rdy is high.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_ack;
  logic       rx_perr;
  logic       rx_ferr;
  logic       rx_ovr;

  // master: the receiver that produces bytes; slave: the consumer that acks them
  modport master (
    output rx_data,
    output rx_rdy,
    output rx_perr,
    output rx_ferr,
    output rx_ovr,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_rdy,
    input  rx_perr,
    input  rx_ferr,
    input  rx_ovr,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit, mid-bit sampling.
// Each byte is presented with parity/framing/overrun flags on a rdy/ack handshake.
module uart_rx #(
  parameter int    CLKS_PER_BIT = 16,
  parameter string PARITY       = "NONE"
) (
  input  logic        inclk,
  input  logic        rst,
  input  logic        rxd,
  uart_rx_if.master   rx_if,
  output logic [2:0]  o_dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam bit HAS_PAR = (PARITY != "NONE");
  localparam bit ODD_PAR = (PARITY == "ODD");

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BRK    = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_par_err;
  logic [7:0]    r_data;
  logic          r_rdy;
  logic          r_perr;
  logic          r_ferr;
  logic          r_ovr;

  state_t        w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [3:0]    w_bit_nx;
  logic [7:0]    w_shift_nx;
  logic          w_par_err_nx;
  logic          w_commit;
  logic          w_rxd_s;
  logic          w_full;
  logic          w_exp_par;

  assign w_rxd_s   = r_sync2;
  assign w_full    = (r_cnt == FULL_M1);
  assign w_exp_par = ODD_PAR ? ~(^r_shift) : (^r_shift);

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= 4'd0;
      r_shift   <= 8'h00;
      r_par_err <= 1'b0;
    end else begin
      r_sync1   <= rxd;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_bit     <= w_bit_nx;
      r_shift   <= w_shift_nx;
      r_par_err <= w_par_err_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_bit_nx     = r_bit;
    w_shift_nx   = r_shift;
    w_par_err_nx = r_par_err;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxd_s) begin
          w_state_nx   = S_START;
          w_cnt_nx     = '0;
          w_bit_nx     = 4'd0;
          w_par_err_nx = 1'b0;
        end
      end
      S_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (r_cnt == HALF_M1) begin
          w_cnt_nx   = '0;
          w_state_nx = w_rxd_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_full) begin
          w_cnt_nx   = '0;
          w_shift_nx = {w_rxd_s, r_shift[7:1]};
          if (r_bit == 4'd7) begin
            w_bit_nx   = 4'd0;
            w_state_nx = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            w_bit_nx = r_bit + 4'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_PARITY: begin
        if (w_full) begin
          w_cnt_nx     = '0;
          w_par_err_nx = (w_rxd_s != w_exp_par);
          w_state_nx   = S_STOP;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        // Low stop bit: park in BRK so a held-low line cannot retrigger.
        if (w_full) begin
          w_cnt_nx   = '0;
          w_commit   = 1'b1;
          w_state_nx = w_rxd_s ? S_IDLE : S_BRK;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_BRK: begin
        if (w_rxd_s) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Handshake: rx_rdy rises on a commit and falls on the edge that samples
  // rx_ack high; a commit on that same edge wins, so the new byte replaces the
  // old one and rx_rdy stays high. A commit while rx_rdy is held without ack
  // drops the frame and raises rx_ovr. rx_ack while rx_rdy is low is ignored.
  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      r_data <= 8'h00;
      r_rdy  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else if (w_commit) begin
      if (!r_rdy || rx_if.rx_ack) begin
        r_data <= r_shift;
        r_perr <= r_par_err;
        r_ferr <= ~w_rxd_s;
        r_rdy  <= 1'b1;
        r_ovr  <= 1'b0;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (r_rdy && rx_if.rx_ack) begin
      r_rdy  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end
  end

  assign rx_if.rx_data = r_data;
  assign rx_if.rx_rdy  = r_rdy;
  assign rx_if.rx_perr = r_perr;
  assign rx_if.rx_ferr = r_ferr;
  assign rx_if.rx_ovr  = r_ovr;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks/bit with odd parity.
// Table-driven single frames, then hand-written break, glitch, overrun and reset sequences.
module tb_uart_rx;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_STOP = 3'd4;
  localparam logic [2:0] ST_BRK  = 3'd5;

  logic       inclk;
  logic       rst;
  logic       rxd;
  logic [2:0] dbg_state;
  int         n_checks;
  int         n_fail;
  logic [7:0] exp_q[$];

  uart_rx_if u_if ();

  uart_rx #(
    .CLKS_PER_BIT(16),
    .PARITY("ODD")
  ) dut (
    .inclk(inclk),
    .rst(rst),
    .rxd(rxd),
    .rx_if(u_if),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stp;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (16) @(negedge inclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stp);
  endtask

  task automatic idle(input int cycles);
    rxd = 1'b1;
    repeat (cycles) @(negedge inclk);
  endtask

  task automatic ack_pulse();
    @(negedge inclk);
    u_if.rx_ack = 1'b1;
    @(negedge inclk);
    u_if.rx_ack = 1'b0;
  endtask

  task automatic wait_rdy(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (u_if.rx_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge inclk);
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic chk_out(input string name, input logic [7:0] d, input logic rdy,
                         input logic perr, input logic ferr, input logic ovr);
    chk({name, "_data"}, {24'd0, u_if.rx_data}, {24'd0, d});
    chk({name, "_rdy"},  {31'd0, u_if.rx_rdy},  {31'd0, rdy});
    chk({name, "_perr"}, {31'd0, u_if.rx_perr}, {31'd0, perr});
    chk({name, "_ferr"}, {31'd0, u_if.rx_ferr}, {31'd0, ferr});
    chk({name, "_ovr"},  {31'd0, u_if.rx_ovr},  {31'd0, ovr});
  endtask

  initial begin
    bit         found;
    logic [7:0] exp_b;

    n_checks = 0;
    n_fail   = 0;

    // Odd parity: parity bit = 1 when the byte holds an even count of ones.
    vecs[0] = '{data: 8'h55, par: 1'b1, stp: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hA3, par: 1'b0, stp: 1'b1, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'h00, par: 1'b1, stp: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'hFF, par: 1'b1, stp: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h80, par: 1'b0, stp: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[5] = '{data: 8'h0F, par: 1'b0, stp: 1'b1, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[6] = '{data: 8'h96, par: 1'b1, stp: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b1};

    rst         = 1'b1;
    rxd         = 1'b1;
    u_if.rx_ack = 1'b0;
    repeat (3) @(negedge inclk);
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst = 1'b0;
    idle(8);

    // table-driven single frames
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stp);
      rxd = 1'b1;
      wait_rdy($sformatf("v%0d_rdy_seen", i), 40);
      exp_b = exp_q.pop_front();
      chk_out($sformatf("v%0d", i), exp_b, 1'b1, vecs[i].exp_perr, vecs[i].exp_ferr, 1'b0);
      ack_pulse();
      chk_out($sformatf("v%0d_acked", i), exp_b, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(32);
    end

    // stop bit low, line held low: one framing-error byte, no retrigger
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (48) @(negedge inclk);
    chk_out("brk", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("brk_state", {29'd0, dbg_state}, {29'd0, ST_BRK});
    ack_pulse();
    idle(40);
    chk("brk_no_second", {31'd0, u_if.rx_rdy}, 32'd0);
    chk("brk_idle_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    send_frame(8'h01, 1'b0, 1'b1);
    wait_rdy("after_brk_rdy_seen", 40);
    chk_out("after_brk", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    ack_pulse();
    idle(32);

    // short low glitch must be rejected
    rxd = 1'b0;
    repeat (4) @(negedge inclk);
    idle(30);
    chk("glitch_rdy", {31'd0, u_if.rx_rdy}, 32'd0);
    chk("glitch_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    send_frame(8'h7E, 1'b1, 1'b1);
    wait_rdy("after_glitch_rdy_seen", 40);
    chk_out("after_glitch", 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
    ack_pulse();
    idle(32);

    // back-to-back without ack: second frame dropped, overrun flagged
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    idle(4);
    chk_out("ovr", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    ack_pulse();
    chk_out("ovr_acked", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(32);

    // ack lands exactly on the second frame's stop-sample edge
    send_frame(8'h11, 1'b1, 1'b1);
    fork
      send_frame(8'h22, 1'b1, 1'b1);
      begin
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
          @(negedge inclk);
          if (dbg_state == ST_STOP) found = 1'b1;
        end
        chk("coack_stop_seen", {31'd0, found}, 32'd1);
        if (found) begin
          repeat (15) @(negedge inclk);
          chk("coack_before_data", {24'd0, u_if.rx_data}, 32'h11);
          u_if.rx_ack = 1'b1;
          @(negedge inclk);
          u_if.rx_ack = 1'b0;
          chk_out("coack", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        end
      end
    join
    idle(4);
    chk_out("coack_hold", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset during data bit 4 with a byte still pending
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        repeat (5 * 16 + 8) @(negedge inclk);
        rst = 1'b1;
        #1;
        chk_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      end
    join
    @(negedge inclk);
    rst = 1'b0;
    idle(40);
    chk("rst_no_rdy", {31'd0, u_if.rx_rdy}, 32'd0);
    send_frame(8'hC5, 1'b1, 1'b1);
    wait_rdy("after_rst_rdy_seen", 40);
    chk_out("after_rst", 8'hC5, 1'b1, 1'b0, 1'b0, 1'b0);
    ack_pulse();
    chk("after_rst_acked", {31'd0, u_if.rx_rdy}, 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
